// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, controller states, Rcon, S-boxes
// and the forward/inverse key-schedule steps used by the iterative decryptor.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        KEYX,
        ROUND,
        DONE
    } fsm_t;

    // Padded to 16 entries so a 4-bit round counter indexes it without range checks.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] rot_sub_word(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ rot_sub_word(rk[31:0], rc);
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_step_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ rot_sub_word(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_shifted;
    logic [127:0] w_subbed;
    logic [127:0] w_keyed;
    logic [127:0] w_mixed;

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    // Byte 4*c+r is row r of column c; row r rotates right by r columns.
    always_comb begin
        // NOTE: default-assign every combinational output first so no path can infer a latch.
        w_shifted = '0;
        w_subbed  = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shifted[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            w_subbed[127-8*i -: 8] = inv_sbox(w_shifted[127-8*i -: 8]);
        end
    end

    assign w_keyed = w_subbed ^ i_round_key;

    always_comb begin
        w_mixed = '0;
        for (int c = 0; c < 4; c++) begin
            w_mixed[127-32*c -: 32] = inv_mix_column(w_keyed[127-32*c -: 32]);
        end
    end

    assign o_state = i_last ? w_keyed : w_mixed;

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 ECB decryptor: 10 cycles of forward key expansion to reach
// rk10, then 10 inverse rounds that walk the key schedule back down to rk0.
module aes_128_dec_iter #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    import aes_pkg::*;

    fsm_t         r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_key;
    logic [127:0] r_state;
    logic [127:0] r_pt;
    logic         r_out_valid;
    logic         r_in_ready;

    logic [3:0]   w_rcon_idx;
    logic [7:0]   w_rcon;
    logic [127:0] w_key_step;
    logic         w_last;
    logic [127:0] w_round_out;

    // Expansion uses Rcon[r]; the backward walk out of rk_(r+1) needs Rcon[r+1].
    assign w_rcon_idx = (r_fsm == ROUND) ? r_round + 4'd1 : r_round;
    assign w_rcon     = RCON[w_rcon_idx];
    assign w_key_step = (r_fsm == ROUND) ? key_step_inv(r_key, w_rcon)
                                         : key_step_fwd(r_key, w_rcon);
    assign w_last     = (r_round == 4'd0);

    aes_inv_round u_inv_round (
        .i_state     (r_state),
        .i_round_key (w_key_step),
        .i_last      (w_last),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register, datapath included, is cleared so an aborted block leaves nothing behind.
            r_fsm       <= IDLE;
            r_round     <= 4'd0;
            r_key       <= '0;
            r_state     <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_key      <= key;
                        r_state    <= ct;
                        r_round    <= 4'd1;
                        r_in_ready <= 1'b0;
                        r_fsm      <= KEYX;
                    end
                end
                KEYX: begin
                    r_key <= w_key_step;
                    if (r_round == 4'(NR)) begin
                        r_state <= r_state ^ w_key_step;
                        r_round <= 4'(NR - 1);
                        r_fsm   <= ROUND;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ROUND: begin
                    r_key <= w_key_step;
                    if (w_last) begin
                        r_pt        <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_state <= w_round_out;
                        r_round <= r_round - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pt        = r_pt;

endmodule
